final_soc_debug_cmd_sync: RTL and testbench

System-clock side of the Nios II debug slave: synchronises update-IR/update-DR strobes arriving from the JTAG TCK domain, captures the instruction and shift-register contents, and queues commands in a small FIFO so back-to-back JTAG updates are not lost while the CPU debug logic is busy. Each dequeued command drives a one-cycle one-hot `take_action` pulse and a held `jdo` word. This block generalises the fixed 2-bit-IR / 38-bit-SR, unbuffered sysclk stage.

---
 rtl/final_soc_debug_pkg.sv | 20 ++
 rtl/final_soc_debug_cmd_fifo.sv | 57 +++++
 rtl/final_soc_debug_cmd_sync.sv | 117 +++++++++++
 tb/tb_final_soc_debug_cmd_sync.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/final_soc_debug_pkg.sv
// Shared constants, instruction encodings and command type for the
// system-clock side of the debug slave.
package final_soc_debug_pkg;

  localparam int DBG_SR_W = 32'd38;
  localparam int DBG_IR_W = 32'd2;

  typedef enum logic [DBG_IR_W-1:0] {
    DBG_IR_OCIMEM    = 2'd0,
    DBG_IR_TRACECTRL = 2'd1,
    DBG_IR_BREAK     = 2'd2,
    DBG_IR_TRACEMEM  = 2'd3
  } dbg_ir_e;

  typedef struct packed {
    logic [DBG_IR_W-1:0] ir;
    logic [DBG_SR_W-1:0] data;
  } dbg_cmd_t;

endpackage

// File: rtl/final_soc_debug_cmd_fifo.sv
// Synchronous command FIFO; a push into a full queue is accepted when a pop
// frees the head slot in the same cycle, otherwise it is reported as a drop.
module final_soc_debug_cmd_fifo #(
  parameter int W      = 32'd40,
  parameter int DEPTH  = 32'd4,
  localparam int AW    = $clog2(DEPTH),
  localparam int FW    = AW + 32'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [FW-1:0] fill,
  output logic          drop
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [FW-1:0] wr_ptr_r;
  logic [FW-1:0] rd_ptr_r;
  logic          full_s;
  logic          pop_s;
  logic          push_s;

  // Occupancy, accept/drop decisions and head selection.
  always_comb begin
    fill   = wr_ptr_r - rd_ptr_r;
    empty  = (fill == {FW{1'b0}});
    full_s = (fill == FW'(DEPTH));
    pop_s  = pop & ~empty;
    push_s = push & (~full_s | pop_s);
    drop   = push & full_s & ~pop_s;
    head   = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Storage and pointers; the extra pointer bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {FW{1'b0}};
      rd_ptr_r <= {FW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + FW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FW'(1'b1);
      end
    end
  end

endmodule

// File: rtl/final_soc_debug_cmd_sync.sv
// System-clock stage of the debug slave: synchronises JTAG update strobes,
// queues {ir, sr} commands and issues one-hot take_action pulses with held jdo.
module final_soc_debug_cmd_sync
  import final_soc_debug_pkg::*;
#(
  parameter int SR_W       = DBG_SR_W,
  parameter int IR_W       = DBG_IR_W,
  parameter int SYNC_DEPTH = 32'd2,
  parameter int FIFO_DEPTH = 32'd4,
  localparam int NUM_CMD   = 32'd1 << IR_W,
  localparam int FILL_W    = $clog2(FIFO_DEPTH) + 32'd1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [SR_W-1:0]   sr,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic              cmd_ready,
  input  logic              clr_overflow,
  output logic              cmd_valid,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [SR_W-1:0]   cmd_data,
  output logic [SR_W-1:0]   jdo,
  output logic [NUM_CMD-1:0] take_action,
  output logic [FILL_W-1:0] fill,
  output logic              overflow
);

  localparam int CMD_W = IR_W + SR_W;

  logic [SYNC_DEPTH-1:0] uir_sync_r;
  logic [SYNC_DEPTH-1:0] udr_sync_r;
  logic                  uir_hist_r;
  logic                  udr_hist_r;
  logic                  uir_rise_s;
  logic                  udr_rise_s;
  logic [IR_W-1:0]       ir_q_r;
  logic [SR_W-1:0]       jdo_r;
  logic [NUM_CMD-1:0]    take_action_r;
  logic                  overflow_r;
  logic                  pop_s;
  logic                  empty_s;
  logic                  drop_s;
  logic [CMD_W-1:0]      head_s;

  // Two-level synchronisers plus a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_r <= {SYNC_DEPTH{1'b0}};
      udr_sync_r <= {SYNC_DEPTH{1'b0}};
      uir_hist_r <= 1'b0;
      udr_hist_r <= 1'b0;
    end else begin
      uir_sync_r <= {uir_sync_r[SYNC_DEPTH-2:0], vs_uir};
      udr_sync_r <= {udr_sync_r[SYNC_DEPTH-2:0], vs_udr};
      uir_hist_r <= uir_sync_r[SYNC_DEPTH-1];
      udr_hist_r <= udr_sync_r[SYNC_DEPTH-1];
    end
  end

  // Edge strobes and head-of-queue decode.
  always_comb begin
    uir_rise_s = uir_sync_r[SYNC_DEPTH-1] & ~uir_hist_r;
    udr_rise_s = udr_sync_r[SYNC_DEPTH-1] & ~udr_hist_r;
    cmd_valid  = ~empty_s;
    pop_s      = cmd_valid & cmd_ready;
    cmd_ir     = head_s[SR_W +: IR_W];
    cmd_data   = head_s[SR_W-1:0];
  end

  final_soc_debug_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (udr_rise_s),
    .push_data ({ir_q_r, sr}),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (empty_s),
    .fill      (fill),
    .drop      (drop_s)
  );

  // Instruction capture, action pulse, held data and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q_r        <= {IR_W{1'b0}};
      jdo_r         <= {SR_W{1'b0}};
      take_action_r <= {NUM_CMD{1'b0}};
      overflow_r    <= 1'b0;
    end else begin
      if (uir_rise_s) begin
        ir_q_r <= ir_in;
      end
      if (pop_s) begin
        jdo_r         <= cmd_data;
        take_action_r <= NUM_CMD'(1'b1) << cmd_ir;
      end else begin
        take_action_r <= {NUM_CMD{1'b0}};
      end
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign jdo         = jdo_r;
  assign take_action = take_action_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_final_soc_debug_cmd_sync.sv
// Directed bench for final_soc_debug_cmd_sync: reset, single command, burst
// overflow, full-with-pop, simultaneous strobes and asynchronous reset.
module tb_final_soc_debug_cmd_sync;
  import final_soc_debug_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_uir;
  logic        vs_udr;
  logic        cmd_ready;
  logic        clr_overflow;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [2:0]  fill;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  final_soc_debug_cmd_sync dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ir_in        (ir_in),
    .sr           (sr),
    .vs_uir       (vs_uir),
    .vs_udr       (vs_udr),
    .cmd_ready    (cmd_ready),
    .clr_overflow (clr_overflow),
    .cmd_valid    (cmd_valid),
    .cmd_ir       (cmd_ir),
    .cmd_data     (cmd_data),
    .jdo          (jdo),
    .take_action  (take_action),
    .fill         (fill),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic uir_pulse(input logic [1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (4) @(negedge clk);
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic udr_pulse(input logic [37:0] d);
    sr     = d;
    vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Pop the head for one cycle and check head, pulse and held data.
  task automatic drain_one(input logic [1:0] ir, input logic [37:0] d);
    logic [3:0] exp_ta;
    exp_ta = 4'b0001 << ir;
    check_val("head_valid", {63'd0, cmd_valid}, 64'd1);
    check_val("head_ir", {62'd0, cmd_ir}, {62'd0, ir});
    check_val("head_data", {26'd0, cmd_data}, {26'd0, d});
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_val("pop_take_action", {60'd0, take_action}, {60'd0, exp_ta});
    check_val("pop_jdo", {26'd0, jdo}, {26'd0, d});
    @(negedge clk);
    check_val("take_action_clear", {60'd0, take_action}, 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; ir_in = 2'd0; sr = 38'd0; vs_uir = 1'b0; vs_udr = 1'b0;
    cmd_ready = 1'b0; clr_overflow = 1'b0;

    // Reset held while strobes toggle.
    repeat (6) begin
      @(negedge clk);
      vs_uir = ~vs_uir;
      vs_udr = ~vs_udr;
    end
    @(negedge clk);
    check_val("rst_valid", {63'd0, cmd_valid}, 64'd0);
    check_val("rst_fill", {61'd0, fill}, 64'd0);
    check_val("rst_take_action", {60'd0, take_action}, 64'd0);
    check_val("rst_jdo", {26'd0, jdo}, 64'd0);
    check_val("rst_overflow", {63'd0, overflow}, 64'd0);
    vs_uir = 1'b0; vs_udr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("post_rst_valid", {63'd0, cmd_valid}, 64'd0);
    check_val("post_rst_fill", {61'd0, fill}, 64'd0);

    // Single command with exact latency.
    uir_pulse(DBG_IR_BREAK);
    check_val("uir_no_push", {61'd0, fill}, 64'd0);
    cmd_ready = 1'b1;
    sr = 38'h2A_DEAD_BEEF;
    vs_udr = 1'b1;
    repeat (2) @(negedge clk);
    check_val("lat_edge2_valid", {63'd0, cmd_valid}, 64'd0);
    @(negedge clk);
    check_val("lat_edge3_valid", {63'd0, cmd_valid}, 64'd1);
    check_val("single_ir", {62'd0, cmd_ir}, 64'd2);
    check_val("single_data", {26'd0, cmd_data}, 64'h2A_DEAD_BEEF);
    @(negedge clk);
    check_val("single_take_action", {60'd0, take_action}, 64'h4);
    check_val("single_jdo", {26'd0, jdo}, 64'h2A_DEAD_BEEF);
    check_val("single_valid_gone", {63'd0, cmd_valid}, 64'd0);
    @(negedge clk);
    check_val("single_ta_clear", {60'd0, take_action}, 64'd0);
    check_val("single_jdo_held", {26'd0, jdo}, 64'h2A_DEAD_BEEF);
    vs_udr = 1'b0;
    cmd_ready = 1'b0;
    repeat (4) @(negedge clk);

    // Burst of five into a four-deep queue.
    for (int i = 1; i <= 5; i++) udr_pulse(38'(i));
    check_val("burst_fill", {61'd0, fill}, 64'd4);
    check_val("burst_overflow", {63'd0, overflow}, 64'd1);
    for (int i = 1; i <= 4; i++) drain_one(2'd2, 38'(i));
    check_val("burst_empty", {63'd0, cmd_valid}, 64'd0);
    check_val("burst_fill0", {61'd0, fill}, 64'd0);
    check_val("overflow_sticky", {63'd0, overflow}, 64'd1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check_val("overflow_clr", {63'd0, overflow}, 64'd0);

    // Full queue, pop in the cycle the udr edge is detected.
    for (int i = 10; i <= 13; i++) udr_pulse(38'(i));
    check_val("full_fill", {61'd0, fill}, 64'd4);
    sr = 38'd14;
    vs_udr = 1'b1;
    repeat (2) @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_val("fullpop_fill", {61'd0, fill}, 64'd4);
    check_val("fullpop_overflow", {63'd0, overflow}, 64'd0);
    check_val("fullpop_jdo", {26'd0, jdo}, 64'd10);
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 11; i <= 14; i++) drain_one(2'd2, 38'(i));

    // Simultaneous uir/udr edges use the previous instruction.
    uir_pulse(DBG_IR_TRACECTRL);
    ir_in = 2'd3; sr = 38'd100;
    vs_uir = 1'b1; vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    vs_uir = 1'b0; vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    udr_pulse(38'd101);
    check_val("simul_fill", {61'd0, fill}, 64'd2);
    drain_one(2'd1, 38'd100);
    drain_one(2'd3, 38'd101);

    // Asynchronous reset with three commands queued.
    for (int i = 20; i <= 22; i++) udr_pulse(38'(i));
    check_val("mid_fill", {61'd0, fill}, 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_valid_drop", {63'd0, cmd_valid}, 64'd0);
    check_val("async_fill", {61'd0, fill}, 64'd0);
    cmd_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("no_action_after_rst", {60'd0, take_action}, 64'd0);
    end
    check_val("after_rst_valid", {63'd0, cmd_valid}, 64'd0);
    check_val("after_rst_jdo", {26'd0, jdo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
